// File: rtl/farm_mem_pkg.sv
// Shared types and lane helpers for the FARM data-memory path.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package farm_mem_pkg;

    // Access size as encoded on the request interface
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } dmem_state_t;

    // Wide enough for the largest legal wait-state count minus one (14)
    localparam int CNT_W = 4;

    // Byte-lane enables for a naturally aligned access; illegal size enables nothing
    function automatic logic [3:0] be_gen(input mem_size_t size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = 4'b0011 << addr_lo;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across every lane it could land on
    function automatic logic [31:0] wdata_rep(input mem_size_t size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    // Misaligned half/word or the reserved size encoding
    function automatic logic is_fault(input mem_size_t size, input logic [1:0] addr_lo);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = addr_lo[0];
            SZ_WORD: f = (addr_lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/farm_load_align.sv
// Load data aligner: shifts the addressed lane down and sign/zero-extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module farm_load_align
    import farm_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Bring the addressed byte/half into the low lanes, then extend to 32 bits
    always_comb begin
        shifted = raw >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = is_unsigned ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/farm_dmem_ctrl.sv
// Single-outstanding data-memory controller driving a fixed-latency sync SRAM.
// Latency: legal access completes WAIT_CYC+1 cycles after acceptance; faults after 1.
// Backpressure: req_ready only in IDLE; requester holds req_valid until accepted.
module farm_dmem_ctrl
    import farm_mem_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_done,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    dmem_state_t      state;
    logic [CNT_W-1:0] wait_cnt;

    // Captured request fields, stable for the whole transaction
    logic             cap_wr;
    logic [1:0]       cap_addr_lo;
    mem_size_t        cap_size;
    logic             cap_unsigned;

    mem_size_t        req_sz;
    logic             req_bad;
    logic [31:0]      load_val;

    // Address bits above the SRAM window are outside this memory and ignored
    logic             unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    assign req_sz  = mem_size_t'(req_size);
    assign req_bad = is_fault(req_sz, req_addr[1:0]);

    // Only combinational output: accept only in IDLE and never while in reset
    assign req_ready = (state == IDLE) && !rst;

    farm_load_align u_load_align (
        .raw         (sram_rdata),
        .addr_lo     (cap_addr_lo),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .data        (load_val)
    );

    // Sequencer: accept, hold SRAM strobes for WAIT_CYC cycles, pulse completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            cap_wr       <= 1'b0;
            cap_addr_lo  <= 2'b00;
            cap_size     <= SZ_BYTE;
            cap_unsigned <= 1'b0;
            rsp_done     <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_fault    <= 1'b0;
            sram_cs      <= 1'b0;
            sram_we      <= 1'b0;
            sram_be      <= 4'b0000;
            sram_addr    <= '0;
            sram_wdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_wr       <= req_wr;
                        cap_addr_lo  <= req_addr[1:0];
                        cap_size     <= req_sz;
                        cap_unsigned <= req_unsigned;
                        if (req_bad) begin
                            // Faults bypass the SRAM entirely; address/data keep old values
                            state     <= RESP;
                            rsp_done  <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state      <= ACCESS;
                            wait_cnt   <= CNT_W'(WAIT_CYC - 1);
                            sram_cs    <= 1'b1;
                            sram_we    <= req_wr;
                            sram_be    <= be_gen(req_sz, req_addr[1:0]);
                            sram_addr  <= req_addr[MEM_AW+1:2];
                            sram_wdata <= wdata_rep(req_sz, req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        // Last access cycle: read data is valid now
                        state     <= RESP;
                        sram_cs   <= 1'b0;
                        sram_we   <= 1'b0;
                        sram_be   <= 4'b0000;
                        rsp_done  <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= cap_wr ? 32'd0 : load_val;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    rsp_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    rsp_done <= 1'b0;
                    sram_cs  <= 1'b0;
                    sram_we  <= 1'b0;
                    sram_be  <= 4'b0000;
                end
            endcase
        end
    end

endmodule
